// File: rtl/csr_pkg.sv
// Shared CSR definitions: addresses, mstatus/mip bit positions, write masks
// and mcause codes. Also imported by the interrupt controller.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // Counter word addresses in load-vector order: mcycle lo/hi, minstret lo/hi.
  localparam logic [3:0][11:0] CSR_CNT_ADDR =
    {CSR_MINSTRETH, CSR_MINSTRET, CSR_MCYCLEH, CSR_MCYCLE};

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIP_MTIP       = 7;
  localparam int MIP_MEIP       = 11;

  localparam logic [31:0] MSTATUS_WMASK = (32'd1 << MSTATUS_MIE) | (32'd1 << MSTATUS_MPIE);
  localparam logic [31:0] MSTATUS_MPP_M = (32'd1 << MSTATUS_MPP_LO) | (32'd1 << MSTATUS_MPP_HI);
  localparam logic [31:0] MIE_WMASK     = (32'd1 << MIP_MTIP) | (32'd1 << MIP_MEIP);
  localparam logic [31:0] ALIGN4_MASK   = 32'hFFFF_FFFC;

  localparam logic [31:0] MCAUSE_ECALL_M    = 32'd11;
  localparam logic [31:0] MCAUSE_BREAKPOINT = 32'd3;
  localparam logic [31:0] MCAUSE_M_TIMER    = 32'h8000_0007;
  localparam logic [31:0] MCAUSE_M_EXT      = 32'h8000_000B;

  function automatic logic csr_writable(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH, CSR_MINSTRETH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] csr_wmask(input logic [11:0] addr, input logic [31:0] wd);
    case (addr)
      CSR_MSTATUS:          return (wd & MSTATUS_WMASK) | MSTATUS_MPP_M;
      CSR_MIE:              return wd & MIE_WMASK;
      CSR_MTVEC, CSR_MEPC:  return wd & ALIGN4_MASK;
      default:              return wd;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with increment enable and independent word loads.
// A loaded word takes the load value; the other word holds that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  input  logic        i_ld_lo,
  input  logic [31:0] i_d_lo,
  input  logic        i_ld_hi,
  input  logic [31:0] i_d_hi,
  output logic [63:0] o_count
);

  logic [63:0] r_count;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_ld_lo || i_ld_hi) begin
      if (i_ld_lo) r_count[31:0]  <= i_d_lo;
      if (i_ld_hi) r_count[63:32] <= i_d_hi;
    end else if (i_inc) begin
      r_count <= r_count + 64'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: two write initiators (interrupt controller, EX stage),
// combinational EX read port with clint bypass, and mcycle/minstret counters.
module csr_regfile
  import csr_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_we,
  input  logic [11:0] ex_wa,
  input  logic [31:0] ex_wd,
  input  logic [11:0] ex_ra,
  output logic [31:0] ex_rd,
  output logic        ex_illegal,
  input  logic        clint_we,
  input  logic [11:0] clint_wa,
  input  logic [31:0] clint_wd,
  input  logic        retire,
  input  logic [7:0]  irq_pending,
  output logic [31:0] csr_mtvec,
  output logic [31:0] csr_mepc,
  output logic [31:0] csr_mstatus,
  output logic        interrupt_enable
);

  logic [31:0]      r_mstatus, r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mip;
  logic             w_clint_ok, w_ex_ok;
  logic [31:0]      w_clint_wd_m, w_ex_wd_m;
  logic [3:0]       w_cnt_ld;
  logic [3:0][31:0] w_cnt_d;
  logic [63:0]      w_mcycle, w_minstret;
  logic             w_unused_irq;

  assign w_unused_irq = ^irq_pending[7:2];

  assign w_clint_ok = clint_we & csr_writable(clint_wa);
  // A same-address collision drops the EX write so the interrupt controller wins.
  assign w_ex_ok    = ex_we & csr_writable(ex_wa) & ~(w_clint_ok & (clint_wa == ex_wa));
  assign w_clint_wd_m = csr_wmask(clint_wa, clint_wd);
  assign w_ex_wd_m    = csr_wmask(ex_wa, ex_wd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mstatus  <= MSTATUS_MPP_M;
      r_mie      <= '0;
      r_mtvec    <= RESET_MTVEC & ALIGN4_MASK;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mip      <= '0;
    end else begin
      r_mip <= {20'd0, irq_pending[1], 3'd0, irq_pending[0], 7'd0};
      if (w_ex_ok) begin
        case (ex_wa)
          CSR_MSTATUS:  r_mstatus  <= w_ex_wd_m;
          CSR_MIE:      r_mie      <= w_ex_wd_m;
          CSR_MTVEC:    r_mtvec    <= w_ex_wd_m;
          CSR_MSCRATCH: r_mscratch <= w_ex_wd_m;
          CSR_MEPC:     r_mepc     <= w_ex_wd_m;
          CSR_MCAUSE:   r_mcause   <= w_ex_wd_m;
          default: ;
        endcase
      end
      if (w_clint_ok) begin
        case (clint_wa)
          CSR_MSTATUS:  r_mstatus  <= w_clint_wd_m;
          CSR_MIE:      r_mie      <= w_clint_wd_m;
          CSR_MTVEC:    r_mtvec    <= w_clint_wd_m;
          CSR_MSCRATCH: r_mscratch <= w_clint_wd_m;
          CSR_MEPC:     r_mepc     <= w_clint_wd_m;
          CSR_MCAUSE:   r_mcause   <= w_clint_wd_m;
          default: ;
        endcase
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_cnt_ld = '0;
    w_cnt_d  = '0;
    for (int i = 0; i < 4; i++) begin
      if (w_ex_ok && ex_wa == CSR_CNT_ADDR[i]) begin
        w_cnt_ld[i] = 1'b1;
        w_cnt_d[i]  = ex_wd;
      end
      if (w_clint_ok && clint_wa == CSR_CNT_ADDR[i]) begin
        w_cnt_ld[i] = 1'b1;
        w_cnt_d[i]  = clint_wd;
      end
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (1'b1),
    .i_ld_lo (w_cnt_ld[0]),
    .i_d_lo  (w_cnt_d[0]),
    .i_ld_hi (w_cnt_ld[1]),
    .i_d_hi  (w_cnt_d[1]),
    .o_count (w_mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (retire),
    .i_ld_lo (w_cnt_ld[2]),
    .i_d_lo  (w_cnt_d[2]),
    .i_ld_hi (w_cnt_ld[3]),
    .i_d_hi  (w_cnt_d[3]),
    .o_count (w_minstret)
  );

  // EX read is read-before-write for its own writes; only clint writes bypass.
  always_comb begin
    ex_rd      = '0;
    ex_illegal = 1'b0;
    case (ex_ra)
      CSR_MSTATUS:                 ex_rd = r_mstatus;
      CSR_MIE:                     ex_rd = r_mie;
      CSR_MTVEC:                   ex_rd = r_mtvec;
      CSR_MSCRATCH:                ex_rd = r_mscratch;
      CSR_MEPC:                    ex_rd = r_mepc;
      CSR_MCAUSE:                  ex_rd = r_mcause;
      CSR_MIP:                     ex_rd = r_mip;
      CSR_MCYCLE,    CSR_CYCLE:    ex_rd = w_mcycle[31:0];
      CSR_MCYCLEH,   CSR_CYCLEH:   ex_rd = w_mcycle[63:32];
      CSR_MINSTRET,  CSR_INSTRET:  ex_rd = w_minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: ex_rd = w_minstret[63:32];
      CSR_MHARTID:                 ex_rd = HART_ID;
      default:                     ex_illegal = 1'b1;
    endcase
    if (w_clint_ok && clint_wa == ex_ra) ex_rd = w_clint_wd_m;
  end

  assign csr_mtvec        = r_mtvec;
  assign csr_mepc         = r_mepc;
  assign csr_mstatus      = r_mstatus;
  assign interrupt_enable = r_mstatus[MSTATUS_MIE] & (|(r_mie & r_mip));

endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
- Machine-mode CSR register file for the pipeline.
- Responder for two CSR write initiators:
  - the interrupt controller, which writes mepc/mstatus/mcause during trap entry and mret;
  - the EX stage, which executes csrrw/csrrs/csrrc and computes the final write data itself.
- Supplies mtvec, mepc, mstatus and the global interrupt enable back to the interrupt controller.
- Holds the 64-bit cycle and instret counters.

Parameters:
- RESET_MTVEC, 32'h0000_0000, reset value of mtvec (bits [1:0] forced 0).
- HART_ID, 32'd0, value returned by mhartid.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ex_we  in  1  EX-stage CSR write enable
- ex_wa  in  12  EX write address
- ex_wd  in  32  EX write data (final value; set/clear already resolved)
- ex_ra  in  12  EX read address
- ex_rd  out  32  EX read data (combinational)
- ex_illegal  out  1  ex_ra is not an implemented CSR (combinational)
- clint_we  in  1  interrupt-controller CSR write enable
- clint_wa  in  12  interrupt-controller write address
- clint_wd  in  32  interrupt-controller write data
- retire  in  1  one instruction retired this cycle
- irq_pending  in  8  raw interrupt lines; bit0 → mip.MTIP(7), bit1 → mip.MEIP(11)
- csr_mtvec  out  32  registered mtvec
- csr_mepc  out  32  registered mepc
- csr_mstatus  out  32  registered mstatus
- interrupt_enable  out  1  mstatus.MIE AND (mie & mip) != 0, from registered values

Behaviour:
- **Implemented addresses** (constants in package):
  - mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344 (read-only);
  - mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82;
  - read-only aliases cycle 0xC00, instret 0xC02, cycleh 0xC80, instreth 0xC82, and mhartid 0xF14.
- **Reset values:**
  - all registers 0, except mtvec = RESET_MTVEC & ~3 and mstatus.MPP[12:11] = 2'b11;
  - outputs therefore come out of reset as: csr_mstatus = 32'h0000_1800, csr_mepc = 0, interrupt_enable = 0.
- **Write masks:**
  - mstatus: only MIE[3] and MPIE[7] are writable; MPP is hardwired 11; all other bits read 0.
  - mie: only bits 7 and 11 are writable.
  - mtvec[1:0] and mepc[1:0] are hardwired 0.
  - mcause is fully writable.
- **Write latency:** writes commit on the rising clk edge; the new value is visible on registered outputs the next cycle.
- **Simultaneous writes:**
  - Different addresses: both commit in the same cycle.
  - Same address: the clint write wins and the ex write is dropped.
- **Illegal and read-only targets:** writes to unimplemented or read-only addresses (mip, aliases, mhartid) are silently ignored.
- **ex_rd:**
  - Unimplemented address: ex_rd = 0 and ex_illegal = 1.
  - Same-cycle clint write to ex_ra: ex_rd returns the masked clint_wd (bypass).
  - A same-cycle ex write is NOT bypassed; read-before-write semantics apply.
- **mip:** sampled from irq_pending every cycle into a register (one-cycle latency).
- **mcycle:** increments by 1 every cycle.
  - A write to mcycle loads the low word; a write to mcycleh loads the high word.
  - In a write cycle the written half takes the written value (no +1) and the other half holds.
  - Wraps 0xFFFF_FFFF_FFFF_FFFF → 0.
  - Carry from low to high occurs in the same cycle.
- **minstret:** identical to mcycle, but increments only when retire = 1.
- **Reset mid-operation:** all state returns to reset values asynchronously; counters restart from 0 on the first edge after rst deasserts.
- **No internal FSM** beyond the counters; each edge is independent.

Decomposition:
- **Package csr_pkg:**
  - 12-bit address constants;
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11);
  - write-mask constants;
  - mcause codes (11 ecall, 3 ebreak, 0x80000007 timer, 0x8000000B external).
  - The interrupt controller also uses this package.
- **Sub-module csr_counter64:** 64-bit counter with an increment enable and independent low/high word load. It is instantiated twice, for mcycle and minstret.

Test Plan:
1. **Reset values:** assert rst for 3 cycles, then release → csr_mstatus = 32'h0000_1800, csr_mtvec = RESET_MTVEC & ~3, ex_ra = 0xF14 reads HART_ID, mcycle reads 1 on the second cycle after release.
2. **Masked writes:** ex write mstatus = 32'hFFFF_FFFF → next cycle csr_mstatus = 32'h0000_1888. ex write mtvec = 32'h8000_0103 → csr_mtvec = 32'h8000_0100.
3. **Address collision:** same cycle clint write mepc = 32'h0000_0040 and ex write mepc = 32'h0000_0080 → mepc = 0x40. Repeat with ex targeting mscratch → both commit.
4. **Bypass:** clint write mcause = 32'h0000_000B with ex_ra = 0x342 in the same cycle → ex_rd = 0xB. ex write mscratch = 5 with ex_ra = 0x340 in the same cycle → ex_rd returns the old value.
5. **Counter load and wrap:**
   - write mcycle = 32'hFFFF_FFFE, then mcycleh = 32'hFFFF_FFFF → after 2 further cycles the counter wraps to 0 and the high word reads 0;
   - pulse retire 5 times → minstret = 5.
6. **Interrupt enable and illegal access:**
   - set mie bit7 and mstatus.MIE, drive irq_pending = 8'h01 → interrupt_enable rises 1 cycle later;
   - ex_ra = 0x7C0 → ex_illegal = 1, ex_rd = 0;
   - a write to 0xC00 leaves the cycle count unchanged.
